mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline, between EX/MEM and MEM/WB registers.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_access_stage_load_align.sv | 37 +++
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, funct3 encodings and access-size decode.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Size ignores the sign bit so LBU/LHU decode like LB/LH; anything else is a word.
    function automatic size_t acc_size(input logic [2:0] f3);
        case ({1'b0, f3[1:0]})
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load aligner: picks the byte/half lane from the read word and sign/zero-extends.
// Zero latency, no flow control; unlisted funct3 values pass the whole word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = rdata_i[7:0];
        case (off_i)
            2'd0: byte_w = rdata_i[7:0];
            2'd1: byte_w = rdata_i[15:8];
            2'd2: byte_w = rdata_i[23:16];
            2'd3: byte_w = rdata_i[31:24];
            default: byte_w = rdata_i[7:0];
        endcase
        half_w = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_w[7]}}, byte_w};
            F3_LH:   data_o = {{16{half_w[15]}}, half_w};
            F3_LBU:  data_o = {24'h0, byte_w};
            F3_LHU:  data_o = {16'h0, half_w};
            F3_LW:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM load/store -> valid/ready dmem transaction, stalling >=2 cycles until ready.
// Request held stable until dmem_ready_i; MEM_MISALIGN_TRAP_EN adds a misaligned-access trap.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   MemRead_i,
    input  logic                   MemWrite_i,
    input  logic [2:0]             funct3_i,
    input  logic [ADDR_W-1:0]      Addr_i,
    input  logic [31:0]            Wdata_i,
    output logic                   Stall_o,
    output logic [31:0]            Memdata_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [ADDR_W-1:0]      dmem_addr_o,
    output logic [31:0]            dmem_wdata_o,
    output logic [3:0]             dmem_be_o,
    input  logic                   dmem_ready_i,
    input  logic [31:0]            dmem_rdata_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   misalign_o
);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [2:0]             funct3_q;
    logic                   we_q;
    logic [31:0]            wdata_q;
    logic [3:0]             be_q;
    logic [31:0]            memdata_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic        stall, req, latch;
    logic [31:0] wd_lane, align_data;
    logic [3:0]  be_lane;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    logic misaligned;
    assign misaligned = ((acc_size(funct3_i) == SZ_WORD) && (Addr_i[1:0] != 2'b00)) ||
                        ((acc_size(funct3_i) == SZ_HALF) && Addr_i[0]);
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        req     = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead_i || MemWrite_i) begin
                    stall = 1'b1;
                    latch = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    state_d = misaligned ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                stall = 1'b1;
                req   = 1'b1;
                if (dmem_ready_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store data is replicated across lanes; the byte enables select the live one.
    always_comb begin
        wd_lane = Wdata_i;
        be_lane = 4'b1111;
        case (acc_size(funct3_i))
            SZ_BYTE: begin
                wd_lane = {4{Wdata_i[7:0]}};
                be_lane = 4'b0001 << Addr_i[1:0];
            end
            SZ_HALF: begin
                wd_lane = {2{Wdata_i[15:0]}};
                be_lane = 4'b0011 << {Addr_i[1], 1'b0};
            end
            default: begin
                wd_lane = Wdata_i;
                be_lane = 4'b1111;
            end
        endcase
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (align_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            memdata_q   <= '0;
            stall_cnt_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q   <= Addr_i;
                funct3_q <= funct3_i;
                we_q     <= MemWrite_i;
                wdata_q  <= wd_lane;
                be_q     <= be_lane;
            end
            if ((state_q == REQ) && dmem_ready_i && !we_q) memdata_q <= align_data;
`ifdef MEM_MISALIGN_TRAP_EN
            if (latch) mis_q <= misaligned;
            if (latch && misaligned) memdata_q <= '0;
`endif
            if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign Stall_o      = stall;
    assign Memdata_o    = memdata_q;
    assign dmem_req_o   = req;
    assign dmem_we_o    = req & we_q;
    assign dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign stall_cnt_o  = stall_cnt_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o   = (state_q == DONE) & mis_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the bench drives dmem_ready_i as the memory.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] Addr_i, Wdata_i;
    logic        Stall_o;
    logic [31:0] Memdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic [15:0] stall_cnt_o;
    logic        misalign_o;

    always #5 clk_i = ~clk_i;

    mem_access_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .funct3_i     (funct3_i),
        .Addr_i       (Addr_i),
        .Wdata_i      (Wdata_i),
        .Stall_o      (Stall_o),
        .Memdata_o    (Memdata_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i),
        .stall_cnt_o  (stall_cnt_o),
        .misalign_o   (misalign_o)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int exp_cnt   = 0;

    int          st, rq;
    logic        stable, done_seen;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access, answers with ready after `waits` REQ cycles, returns in the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits);
        logic [31:0] first_addr;
        @(negedge clk_i);
        MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; Addr_i = addr; Wdata_i = wd;
        dmem_ready_i = 1'b0; dmem_rdata_i = 32'h5A5A5A5A;
        st = 0; rq = 0; stable = 1'b1; done_seen = 1'b0; first_addr = '0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c > 0 && !Stall_o) begin
                done_seen = 1'b1;
                MemRead_i = 1'b0; MemWrite_i = 1'b0;
                break;
            end
            if (Stall_o) st++;
            if (dmem_req_o) begin
                if (rq == 0) first_addr = dmem_addr_o;
                else if (dmem_addr_o !== first_addr) stable = 1'b0;
                cap_addr = dmem_addr_o; cap_wd = dmem_wdata_o;
                cap_be = dmem_be_o; cap_we = dmem_we_o;
                rq++;
                if (rq > waits) begin
                    dmem_ready_i = 1'b1;
                    dmem_rdata_i = rdata;
                end
            end
            @(negedge clk_i);
            dmem_ready_i = 1'b0;
            dmem_rdata_i = 32'h5A5A5A5A;
        end
        if (!done_seen) begin
            MemRead_i = 1'b0; MemWrite_i = 1'b0;
        end
        check("access_done", {31'h0, done_seen}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; funct3_i = 3'b000;
        Addr_i = '0; Wdata_i = '0; dmem_ready_i = 1'b0; dmem_rdata_i = '0;
        #12;
        check("rst_req",      {31'h0, dmem_req_o}, 32'h0);
        check("rst_we",       {31'h0, dmem_we_o},  32'h0);
        check("rst_stall",    {31'h0, Stall_o},    32'h0);
        check("rst_memdata",  Memdata_o,           32'h0);
        check("rst_addr",     dmem_addr_o,         32'h0);
        check("rst_wdata",    dmem_wdata_o,        32'h0);
        check("rst_be",       {28'h0, dmem_be_o},  32'h0);
        check("rst_cnt",      {16'h0, stall_cnt_o}, 32'h0);
        check("rst_misalign", {31'h0, misalign_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // LW 0x100, ready first REQ cycle
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0);
        exp_cnt += 2;
        check("lw_stalls",  st,          32'd2);
        check("lw_addr",    cap_addr,    32'h100);
        check("lw_we",      {31'h0, cap_we}, 32'h0);
        check("lw_data",    Memdata_o,   32'h12345678);
        check("lw_cnt",     {16'h0, stall_cnt_o}, exp_cnt);

        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        exp_cnt += 2;
        check("lb_addr",    cap_addr,  32'h100);
        check("lb_data",    Memdata_o, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        exp_cnt += 2;
        check("lbu_data",   Memdata_o, 32'h00000080);
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0);
        exp_cnt += 2;
        check("lh_data",    Memdata_o, 32'hFFFF8001);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0);
        exp_cnt += 2;
        check("lhu_data",   Memdata_o, 32'h00008001);

        // SH 0x102
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0);
        exp_cnt += 2;
        check("sh_stalls",  st,                   32'd2);
        check("sh_be",      {28'h0, cap_be},      32'hC);
        check("sh_wdata",   {16'h0, cap_wd[31:16]}, 32'hBEEF);
        check("sh_we",      {31'h0, cap_we},      32'h1);
        check("sh_addr",    cap_addr,             32'h100);
        check("sh_keep",    Memdata_o,            32'h00008001);

        // Read and write both set: store SB 0x101
        access(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0);
        exp_cnt += 2;
        check("sb_we",      {31'h0, cap_we},      32'h1);
        check("sb_be",      {28'h0, cap_be},      32'h2);
        check("sb_wdata",   {24'h0, cap_wd[15:8]}, 32'hAB);
        check("sb_keep",    Memdata_o,            32'h00008001);

        // LW with three wait cycles
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 3);
        exp_cnt += 5;
        check("wait_stalls", st,                   32'd5);
        check("wait_reqs",   rq,                   32'd4);
        check("wait_stable", {31'h0, stable},      32'h1);
        check("wait_addr",   cap_addr,             32'h40);
        check("wait_data",   Memdata_o,            32'hDEADBEEF);
        check("wait_cnt",    {16'h0, stall_cnt_o}, exp_cnt);

        // Non-memory cycle: nothing happens, data held
        @(negedge clk_i);
        #1;
        check("idle_stall", {31'h0, Stall_o},    32'h0);
        check("idle_req",   {31'h0, dmem_req_o}, 32'h0);
        check("idle_data",  Memdata_o,           32'hDEADBEEF);

`ifdef MEM_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hA5A5A5A5, 0);
        exp_cnt += 1;
        check("mis_stalls", st,                   32'd1);
        check("mis_reqs",   rq,                   32'd0);
        check("mis_flag",   {31'h0, misalign_o},  32'h1);
        check("mis_data",   Memdata_o,            32'h0);
`else
        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hA5A5A5A5, 0);
        exp_cnt += 2;
        check("trunc_stalls", st,                  32'd2);
        check("trunc_addr",   cap_addr,            32'h100);
        check("trunc_flag",   {31'h0, misalign_o}, 32'h0);
        check("trunc_data",   Memdata_o,           32'hA5A5A5A5);
`endif
        check("post_cnt", {16'h0, stall_cnt_o}, exp_cnt);
        @(negedge clk_i);
        #1;
        check("post_flag", {31'h0, misalign_o}, 32'h0);

        // Reset asserted while in REQ
        @(negedge clk_i);
        MemRead_i = 1'b1; funct3_i = 3'b010; Addr_i = 32'h300; dmem_ready_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("mid_req_on", {31'h0, dmem_req_o}, 32'h1);
        MemRead_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check("mid_req_off", {31'h0, dmem_req_o}, 32'h0);
        check("mid_stall",   {31'h0, Stall_o},    32'h0);
        check("mid_cnt",     {16'h0, stall_cnt_o}, 32'h0);
        check("mid_data",    Memdata_o,           32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_cnt = 0;

        access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEBABE, 0);
        exp_cnt += 2;
        check("after_rst_stalls", st,                   32'd2);
        check("after_rst_data",   Memdata_o,            32'hCAFEBABE);
        check("after_rst_cnt",    {16'h0, stall_cnt_o}, exp_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
